// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running raster counters with decoded sync, blank,
// data-enable, active-area coordinates and frame/line strobes. All state
// advances on clk edges with ce=1. An optional delay line re-times every
// output by DLY extra pixel-enable cycles.
module vga_timing_gen #(
    parameter int unsigned CW     = 12,
    parameter int unsigned H_SW   = 120,
    parameter int unsigned H_BP   = 64,
    parameter int unsigned H_EN   = 800,
    parameter int unsigned H_FP   = 56,
    parameter int unsigned V_SW   = 6,
    parameter int unsigned V_BP   = 23,
    parameter int unsigned V_EN   = 600,
    parameter int unsigned V_FP   = 37,
    parameter bit          HS_POL = 1'b1,
    parameter bit          VS_POL = 1'b1,
    parameter int unsigned DLY    = 0
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          ce,
    output logic          hs,
    output logic          vs,
    output logic          hen,
    output logic          ven,
    output logic          de,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          sof,
    output logic          eol
);

    localparam int unsigned H_TOT = H_SW + H_BP + H_EN + H_FP;
    localparam int unsigned V_TOT = V_SW + V_BP + V_EN + V_FP;
    localparam int unsigned H_ACT = H_SW + H_BP;
    localparam int unsigned V_ACT = V_SW + V_BP;
    localparam int unsigned H_FPS = H_ACT + H_EN;
    localparam int unsigned V_FPS = V_ACT + V_EN;

    localparam logic [CW-1:0] H_SW_C   = CW'(H_SW);
    localparam logic [CW-1:0] V_SW_C   = CW'(V_SW);
    localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACT);
    localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACT);
    localparam logic [CW-1:0] H_FPS_C  = CW'(H_FPS);
    localparam logic [CW-1:0] V_FPS_C  = CW'(V_FPS);
    localparam logic [CW-1:0] H_LAST_C = CW'(H_TOT - 1);
    localparam logic [CW-1:0] V_LAST_C = CW'(V_TOT - 1);

    localparam bit CFG_OK = (CW >= 1) && (CW <= 31)
                         && (H_SW >= 1) && (H_BP >= 1) && (H_EN >= 1) && (H_FP >= 1)
                         && (V_SW >= 1) && (V_BP >= 1) && (V_EN >= 1) && (V_FP >= 1)
                         && (DLY <= 15)
                         && (64'(H_TOT) <= (64'd1 << CW))
                         && (64'(V_TOT) <= (64'd1 << CW));

    // Reject configurations whose counters would not fit or have empty regions
    generate
        if (!CFG_OK) begin : g_cfg_err
            $error("vga_timing_gen: illegal parameter set (widths must be >=1, CW must hold H_TOT-1 and V_TOT-1, DLY <= 15)");
        end
    endgenerate

    typedef struct packed {
        logic          hs;
        logic          vs;
        logic          hen;
        logic          ven;
        logic          de;
        logic          sof;
        logic          eol;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
    } tg_t;

    localparam tg_t TG_RST = '{
        hs:  !HS_POL,
        vs:  !VS_POL,
        hen: 1'b0,
        ven: 1'b0,
        de:  1'b0,
        sof: 1'b0,
        eol: 1'b0,
        x:   '0,
        y:   '0
    };

    logic [CW-1:0] hcnt_q, hcnt_d;
    logic [CW-1:0] vcnt_q, vcnt_d;
    logic          h_act_c, v_act_c;
    tg_t           dec_c;
    tg_t           stg_q [0:DLY];
    tg_t           stg_d [0:DLY];

    // Raster position: hcnt wraps at end of line, vcnt steps on each hcnt wrap
    always_comb begin
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (ce) begin
            if (hcnt_q == H_LAST_C) begin
                hcnt_d = '0;
                vcnt_d = (vcnt_q == V_LAST_C) ? '0 : vcnt_q + CW'(1);
            end else begin
                hcnt_d = hcnt_q + CW'(1);
            end
        end
    end

    // Region decode of the current raster position
    always_comb begin
        dec_c   = TG_RST;
        h_act_c = (hcnt_q >= H_ACT_C) && (hcnt_q < H_FPS_C);
        v_act_c = (vcnt_q >= V_ACT_C) && (vcnt_q < V_FPS_C);
        dec_c.hs  = (hcnt_q < H_SW_C) ? HS_POL : !HS_POL;
        dec_c.vs  = (vcnt_q < V_SW_C) ? VS_POL : !VS_POL;
        dec_c.hen = h_act_c;
        dec_c.ven = v_act_c;
        dec_c.de  = h_act_c && v_act_c;
        dec_c.x   = h_act_c ? (hcnt_q - H_ACT_C) : '0;
        dec_c.y   = v_act_c ? (vcnt_q - V_ACT_C) : '0;
        dec_c.sof = (hcnt_q == '0) && (vcnt_q == '0);
        dec_c.eol = (hcnt_q == H_LAST_C);
    end

    // Output pipeline: stage 0 captures the decode, later stages shift on ce
    always_comb begin
        stg_d = stg_q;
        if (ce) begin
            stg_d[0] = dec_c;
            for (int i = 1; i <= int'(DLY); i++) begin
                stg_d[i] = stg_q[i-1];
            end
        end
    end

    // State registers; reset wins over ce and flushes every stage
    always_ff @(posedge clk) begin
        if (!rstn) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
            for (int i = 0; i <= int'(DLY); i++) begin
                stg_q[i] <= TG_RST;
            end
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
            stg_q  <= stg_d;
        end
    end

    assign hs  = stg_q[DLY].hs;
    assign vs  = stg_q[DLY].vs;
    assign hen = stg_q[DLY].hen;
    assign ven = stg_q[DLY].ven;
    assign de  = stg_q[DLY].de;
    assign x   = stg_q[DLY].x;
    assign y   = stg_q[DLY].y;
    assign sof = stg_q[DLY].sof;
    assign eol = stg_q[DLY].eol;

endmodule
